// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- load/store initiator between the execute stage and the memory
// controller's data port.
//
// Accepts one request at a time (req_valid/req_ready), checks width legality
// and alignment, issues a single-cycle mem_en pulse, captures the registered
// read data one cycle later and returns a tagged result with fault flags
// (resp_valid/resp_ready).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_*               request channel (store flag, width code, addr, data, tag)
//   flush               drop the in-flight response
//   resp_*              response channel (data, tag, store flag, fault flags)
//   mem_*               memory data port; mem_rdata is valid the cycle after mem_en
module lsu_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  input  logic                  flush,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [TAG_WIDTH-1:0]  resp_tag,
  output logic                  resp_is_store,
  output logic                  resp_misalign,
  output logic                  resp_illegal,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic                  mem_enwr,
  output logic                  mem_en,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [2:0]            mem_wid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t state, state_nxt;

  logic accept;
  logic illegal;
  logic misalign_raw;
  logic misalign;
  logic fault;

  assign accept = (state == IDLE) && req_valid;

  // Width legality: 111 is never legal; the unsigned variants only make
  // sense for loads.
  assign illegal = (req_funct3 == 3'b111) || (req_is_store && req_funct3[2]);

  // Alignment depends only on the size bits; B/BU never misalign.
  always_comb begin
    misalign_raw = 1'b0;
    case (req_funct3[1:0])
      2'b01:   misalign_raw = req_addr[0];
      2'b10:   misalign_raw = |req_addr[1:0];
      2'b11:   misalign_raw = |req_addr[2:0];
      default: misalign_raw = 1'b0;
    endcase
  end

  // Illegal wins when both apply.
  assign misalign = misalign_raw && !illegal;
  assign fault    = illegal || misalign_raw;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // flush has no effect here; a same-cycle request is still taken
        if (req_valid) state_nxt = fault ? RESP : ISSUE;
      end
      ISSUE: begin
        // the access itself is already on the port; flush only kills the response
        if (flush)              state_nxt = IDLE;
        else if (resp_is_store) state_nxt = RESP;
        else                    state_nxt = CAPTURE;
      end
      CAPTURE: begin
        state_nxt = flush ? IDLE : RESP;
      end
      RESP: begin
        if (flush || resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state-decoded outputs (async reset forces IDLE, so mem_en drops at once)
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_en     = 1'b0;
    mem_enwr   = 1'b1;
    case (state)
      IDLE:  req_ready = 1'b1;
      ISSUE: begin
        mem_en   = 1'b1;
        mem_enwr = ~resp_is_store;
      end
      RESP:  resp_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // The memory-side fields load only when an access will really be issued, so
  // they keep the previous access's values across faulted requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wid   <= 3'b000;
    end else if (accept && !fault) begin
      mem_addr  <= req_addr;
      mem_wdata <= req_wdata;
      mem_wid   <= req_funct3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_tag      <= '0;
      resp_is_store <= 1'b0;
    end else if (accept) begin
      resp_tag      <= req_tag;
      resp_is_store <= req_is_store;
    end
  end

  // resp_data starts at zero for every request; only a completed load
  // overwrites it in CAPTURE, which leaves stores and faults at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_data <= '0;
    end else if (accept) begin
      resp_data <= '0;
    end else if (state == CAPTURE && !flush) begin
      resp_data <= mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_misalign <= 1'b0;
      resp_illegal  <= 1'b0;
    end else if (accept) begin
      resp_misalign <= misalign;
      resp_illegal  <= illegal;
    end else if (state == RESP && (resp_ready || flush)) begin
      resp_misalign <= 1'b0;
      resp_illegal  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;
  localparam int DW = 64;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_is_store;
  logic [2:0]    req_funct3;
  logic [DW-1:0] req_addr, req_wdata;
  logic [TW-1:0] req_tag;
  logic          flush;
  logic          resp_valid, resp_ready;
  logic [DW-1:0] resp_data;
  logic [TW-1:0] resp_tag;
  logic          resp_is_store, resp_misalign, resp_illegal;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
  logic          mem_enwr, mem_en;
  logic [2:0]    mem_wid;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_ctrl #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_tag(req_tag), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .resp_is_store(resp_is_store),
    .resp_misalign(resp_misalign), .resp_illegal(resp_illegal),
    .mem_addr(mem_addr), .mem_enwr(mem_enwr), .mem_en(mem_en),
    .mem_wdata(mem_wdata), .mem_wid(mem_wid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // ---------------- memory model: byte array, registered, extending reads
  logic [7:0]  mem [0:65535];
  logic        poke_en = 1'b0;
  logic [15:0] poke_addr = '0;
  logic [63:0] poke_data = '0;

  function automatic logic [63:0] rd64(input logic [15:0] a);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = mem[16'(a + 16'(i))];
    return r;
  endfunction

  function automatic logic [63:0] ext(input logic [63:0] r, input logic [2:0] w);
    case (w)
      3'b000:  return {{56{r[7]}},  r[7:0]};
      3'b001:  return {{48{r[15]}}, r[15:0]};
      3'b010:  return {{32{r[31]}}, r[31:0]};
      3'b100:  return {56'd0, r[7:0]};
      3'b101:  return {48'd0, r[15:0]};
      3'b110:  return {32'd0, r[31:0]};
      default: return r;
    endcase
  endfunction

  initial mem_rdata = '0;

  always @(posedge clk) begin
    if (poke_en)
      for (int i = 0; i < 8; i++) mem[16'(poke_addr + 16'(i))] = poke_data[8*i +: 8];
    if (mem_en) begin
      if (mem_enwr) mem_rdata <= ext(rd64(mem_addr[15:0]), mem_wid);
      else
        for (int i = 0; i < (1 << mem_wid[1:0]); i++)
          mem[16'(mem_addr[15:0] + 16'(i))] = mem_wdata[8*i +: 8];
    end
  end

  // free-running count of cycles with mem_en high
  int en_count = 0;
  always @(negedge clk) if (mem_en) en_count <= en_count + 1;

  // ---------------- stimulus helpers
  task automatic poke(input logic [15:0] a, input logic [63:0] d);
    @(negedge clk); poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk); poke_en = 1'b0;
  endtask

  // Presents a request in IDLE; returns at the negedge after the accept edge.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, input logic [TW-1:0] tg);
    @(negedge clk);
    req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_tag = tg;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Edges from the accept edge to resp_valid; 99 on timeout.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk); lat++;
    end
    if (!resp_valid) lat = 99;
  endtask

  task automatic ack;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  // ---------------- tests
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
    n_checks++; if (mem_en !== 1'b0 || mem_enwr !== 1'b1) begin n_fail++; $display("FAIL reset_mem_ctl got en=%b enwr=%b exp 0/1", mem_en, mem_enwr); end
    n_checks++; if (resp_data !== 64'd0 || mem_addr !== 64'd0 || resp_tag !== 5'd0) begin n_fail++; $display("FAIL reset_data got %h/%h/%h exp 0", resp_data, mem_addr, resp_tag); end
  endtask

  task automatic test_load;
    int lat, e0;
    poke(16'h1000, 64'h8877665544332211);
    e0 = en_count;
    issue(1'b0, 3'b011, 64'h1000, 64'd0, 5'd5);
    n_checks++; if (mem_en !== 1'b1 || mem_enwr !== 1'b1) begin n_fail++; $display("FAIL ld_issue got en=%b enwr=%b exp 1/1", mem_en, mem_enwr); end
    n_checks++; if (mem_addr !== 64'h1000 || mem_wid !== 3'b011) begin n_fail++; $display("FAIL ld_addr got %h wid %b exp 1000/011", mem_addr, mem_wid); end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL ld_busy got %b exp 0", req_ready); end
    wait_resp(lat);
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL ld_latency got %0d exp 3", lat); end
    n_checks++; if (resp_data !== 64'h8877665544332211) begin n_fail++; $display("FAIL ld_data got %h exp 8877665544332211", resp_data); end
    n_checks++; if (resp_tag !== 5'd5 || resp_is_store !== 1'b0) begin n_fail++; $display("FAIL ld_tag got %0d st %b exp 5/0", resp_tag, resp_is_store); end
    n_checks++; if (resp_misalign !== 1'b0 || resp_illegal !== 1'b0) begin n_fail++; $display("FAIL ld_flags got %b%b exp 00", resp_misalign, resp_illegal); end
    n_checks++; if (en_count - e0 != 1) begin n_fail++; $display("FAIL ld_en_cycles got %0d exp 1", en_count - e0); end
    ack();
    n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL ld_ack got v=%b r=%b exp 0/1", resp_valid, req_ready); end
  endtask

  task automatic test_misalign;
    int lat, e0;
    e0 = en_count;
    issue(1'b0, 3'b001, 64'h1001, 64'd0, 5'd7);
    wait_resp(lat);
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL mis_latency got %0d exp 1", lat); end
    n_checks++; if (resp_misalign !== 1'b1 || resp_illegal !== 1'b0) begin n_fail++; $display("FAIL mis_flags got %b%b exp 10", resp_misalign, resp_illegal); end
    n_checks++; if (resp_data !== 64'd0 || resp_tag !== 5'd7) begin n_fail++; $display("FAIL mis_data got %h tag %0d exp 0/7", resp_data, resp_tag); end
    n_checks++; if (mem_addr !== 64'h1000) begin n_fail++; $display("FAIL mis_addr_hold got %h exp 1000", mem_addr); end
    ack();
    n_checks++; if (en_count - e0 != 0) begin n_fail++; $display("FAIL mis_no_access got %0d exp 0", en_count - e0); end
    n_checks++; if (resp_misalign !== 1'b0) begin n_fail++; $display("FAIL mis_clear got %b exp 0", resp_misalign); end
  endtask

  task automatic test_store_load;
    int lat;
    issue(1'b1, 3'b010, 64'h2004, 64'hDEADBEEF, 5'd3);
    n_checks++; if (mem_en !== 1'b1 || mem_enwr !== 1'b0 || mem_wid !== 3'b010) begin n_fail++; $display("FAIL sw_issue got en=%b enwr=%b wid=%b exp 1/0/010", mem_en, mem_enwr, mem_wid); end
    n_checks++; if (mem_wdata !== 64'hDEADBEEF || mem_addr !== 64'h2004) begin n_fail++; $display("FAIL sw_port got %h @%h exp deadbeef@2004", mem_wdata, mem_addr); end
    wait_resp(lat);
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL sw_latency got %0d exp 2", lat); end
    n_checks++; if (resp_is_store !== 1'b1 || resp_data !== 64'd0) begin n_fail++; $display("FAIL sw_resp got st=%b data=%h exp 1/0", resp_is_store, resp_data); end
    ack();
    issue(1'b0, 3'b110, 64'h2004, 64'd0, 5'd4);
    wait_resp(lat);
    n_checks++; if (resp_data !== 64'h00000000DEADBEEF) begin n_fail++; $display("FAIL lwu_data got %h exp 00000000deadbeef", resp_data); end
    ack();
    issue(1'b0, 3'b010, 64'h2004, 64'd0, 5'd6);
    wait_resp(lat);
    n_checks++; if (resp_data !== 64'hFFFFFFFFDEADBEEF || lat != 3) begin n_fail++; $display("FAIL lw_data got %h lat %0d exp ffffffffdeadbeef/3", resp_data, lat); end
    ack();
  endtask

  task automatic test_illegal;
    int lat, e0;
    e0 = en_count;
    issue(1'b1, 3'b100, 64'h3001, 64'h55, 5'd9);
    wait_resp(lat);
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL ill_st_latency got %0d exp 1", lat); end
    n_checks++; if (resp_illegal !== 1'b1 || resp_misalign !== 1'b0) begin n_fail++; $display("FAIL ill_st_flags got ill=%b mis=%b exp 1/0", resp_illegal, resp_misalign); end
    ack();
    issue(1'b0, 3'b111, 64'h3000, 64'd0, 5'd10);
    wait_resp(lat);
    n_checks++; if (resp_illegal !== 1'b1 || resp_data !== 64'd0) begin n_fail++; $display("FAIL ill_ld got ill=%b data=%h exp 1/0", resp_illegal, resp_data); end
    ack();
    n_checks++; if (en_count - e0 != 0) begin n_fail++; $display("FAIL ill_no_access got %0d exp 0", en_count - e0); end
  endtask

  task automatic test_backpressure;
    int lat;
    issue(1'b0, 3'b011, 64'h1000, 64'd0, 5'd12);
    wait_resp(lat);
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (resp_valid !== 1'b1 || resp_data !== 64'h8877665544332211 || resp_tag !== 5'd12 || req_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold cyc %0d got v=%b d=%h t=%0d r=%b", c, resp_valid, resp_data, resp_tag, req_ready);
      end
      @(negedge clk);
    end
    ack();
    n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got v=%b r=%b exp 0/1", resp_valid, req_ready); end
  endtask

  task automatic test_flush;
    // flush in CAPTURE
    issue(1'b0, 3'b011, 64'h1000, 64'd0, 5'd1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_cap got v=%b r=%b exp 0/1", resp_valid, req_ready); end
    // flush in ISSUE of a store: write lands, no response
    poke(16'h5000, 64'd0);
    issue(1'b1, 3'b011, 64'h5000, 64'hCAFEF00D12345678, 5'd2);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_iss got v=%b r=%b exp 0/1", resp_valid, req_ready); end
    n_checks++; if (rd64(16'h5000) !== 64'hCAFEF00D12345678) begin n_fail++; $display("FAIL flush_iss_write got %h exp cafef00d12345678", rd64(16'h5000)); end
    // flush in RESP beats resp_ready
    issue(1'b0, 3'b111, 64'h0, 64'd0, 5'd3);
    flush = 1'b1; resp_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; resp_ready = 1'b0;
    n_checks++; if (resp_valid !== 1'b0 || resp_illegal !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_resp got v=%b ill=%b r=%b exp 0/0/1", resp_valid, resp_illegal, req_ready); end
    // flush in IDLE does not block acceptance
    flush = 1'b1;
    issue(1'b0, 3'b011, 64'h1000, 64'd0, 5'd4);
    flush = 1'b0;
    n_checks++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL flush_idle got en=%b exp 1", mem_en); end
    begin
      int lat;
      wait_resp(lat);
      n_checks++; if (lat != 3 || resp_tag !== 5'd4) begin n_fail++; $display("FAIL flush_idle_resp got lat %0d tag %0d exp 3/4", lat, resp_tag); end
    end
    ack();
  endtask

  task automatic test_reset_mid;
    poke(16'h4000, 64'd0);
    issue(1'b1, 3'b010, 64'h4000, 64'h12345678, 5'd8);
    n_checks++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL rstmid_issue got en=%b exp 1", mem_en); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (mem_en !== 1'b0 || mem_enwr !== 1'b1) begin n_fail++; $display("FAIL rstmid_en got en=%b enwr=%b exp 0/1", mem_en, mem_enwr); end
    n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_hs got r=%b v=%b exp 1/0", req_ready, resp_valid); end
    n_checks++; if (mem_addr !== 64'd0 || mem_wdata !== 64'd0 || resp_tag !== 5'd0 || resp_is_store !== 1'b0) begin n_fail++; $display("FAIL rstmid_regs got %h/%h/%0d/%b exp 0", mem_addr, mem_wdata, resp_tag, resp_is_store); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (rd64(16'h4000) !== 64'd0) begin n_fail++; $display("FAIL rstmid_nowrite got %h exp 0", rd64(16'h4000)); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; req_tag = '0; flush = 1'b0; resp_ready = 1'b0;
    test_reset();
    test_load();
    test_misalign();
    test_store_load();
    test_illegal();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
